// File: rtl/cotm32_mdu_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// cotm32_mdu_if: operation encoding package and request/result bus for the MDU.
// Rev 1.0
// ----------------------------------------------------------------------------
package cotm32_mdu_pkg;
  typedef enum logic [3:0] {
    MU_NOP    = 4'd0,
    MU_MUL    = 4'd1,
    MU_MULH   = 4'd2,
    MU_MULHSU = 4'd3,
    MU_MULHU  = 4'd4,
    MU_DIV    = 4'd5,
    MU_DIVU   = 4'd6,
    MU_REM    = 4'd7,
    MU_REMU   = 4'd8
  } mu_op_t;
endpackage

interface cotm32_mdu_if #(
  parameter int XLEN = 32
);
  import cotm32_mdu_pkg::*;

  logic            in_valid;
  logic            in_ready;
  mu_op_t          op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            busy;

  modport master (
    output in_valid, op, a, b, flush, out_ready,
    input  in_ready, out_valid, result, busy
  );

  modport slave (
    input  in_valid, op, a, b, flush, out_ready,
    output in_ready, out_valid, result, busy
  );
endinterface
`default_nettype wire

// File: rtl/cotm32_mdu.sv
`default_nettype none
// ----------------------------------------------------------------------------
// cotm32_mdu: iterative RV32M multiply/divide unit (shift-add / restoring);
// COTM32_MDU_FAST_MUL_EN selects a single-cycle multiplier.  Rev 1.0
// ----------------------------------------------------------------------------
module cotm32_mdu
  import cotm32_mdu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic        clk,
  input  logic        rst,
  cotm32_mdu_if.slave mdu_io
);
  localparam int            CW   = $clog2(XLEN);
  localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  mu_op_t            op_q, op_d;
  logic [XLEN-1:0]   mag_b_q, mag_b_d;
  logic              neg_q, neg_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   result_q, result_d;

  logic              w_is_mul, w_is_div, w_sgn_a, w_sgn_b, w_neg, w_special;
  logic [XLEN-1:0]   w_mag_a, w_mag_b, w_special_res;

  // Accept-cycle decode: magnitudes, result sign and early-out cases.
  always_comb begin
    w_is_mul = mdu_io.op inside {MU_MUL, MU_MULH, MU_MULHSU, MU_MULHU};
    w_is_div = mdu_io.op inside {MU_DIV, MU_DIVU, MU_REM, MU_REMU};
    w_sgn_a  = (mdu_io.op inside {MU_MUL, MU_MULH, MU_MULHSU, MU_DIV, MU_REM})
               && mdu_io.a[XLEN-1];
    w_sgn_b  = (mdu_io.op inside {MU_MUL, MU_MULH, MU_DIV, MU_REM})
               && mdu_io.b[XLEN-1];
    w_mag_a  = w_sgn_a ? -mdu_io.a : mdu_io.a;
    w_mag_b  = w_sgn_b ? -mdu_io.b : mdu_io.b;
    w_neg    = (mdu_io.op inside {MU_REM, MU_REMU}) ? w_sgn_a : (w_sgn_a ^ w_sgn_b);
    w_special     = 1'b0;
    w_special_res = '0;
    if (!w_is_mul && !w_is_div) begin
      w_special = 1'b1;
    end else if (w_is_div && (mdu_io.b == '0)) begin
      w_special     = 1'b1;
      w_special_res = (mdu_io.op inside {MU_DIV, MU_DIVU}) ? '1 : mdu_io.a;
    end else if ((mdu_io.op inside {MU_DIV, MU_REM}) &&
                 (mdu_io.a == {1'b1, {(XLEN-1){1'b0}}}) && (mdu_io.b == '1)) begin
      w_special     = 1'b1;
      w_special_res = (mdu_io.op == MU_DIV) ? mdu_io.a : '0;
    end
  end

`ifdef COTM32_MDU_FAST_MUL_EN
  logic [2*XLEN-1:0] w_fast_fa, w_fast_fb, w_fast_p;
  logic [XLEN-1:0]   w_fast_res;

  // Low 2*XLEN bits of the sign-extended product are exact for every mul op.
  always_comb begin
    w_fast_fa  = {{XLEN{w_sgn_a}}, mdu_io.a};
    w_fast_fb  = {{XLEN{w_sgn_b}}, mdu_io.b};
    w_fast_p   = w_fast_fa * w_fast_fb;
    w_fast_res = (mdu_io.op == MU_MUL) ? w_fast_p[XLEN-1:0] : w_fast_p[2*XLEN-1:XLEN];
  end
`endif

  logic [XLEN:0]     w_sum, w_diff;
  logic [2*XLEN-1:0] w_step, w_prod;
  logic [XLEN-1:0]   w_qr, w_final;

  // acc holds {partial product, multiplier} or {remainder, quotient/dividend}.
  always_comb begin
    w_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, mag_b_q & {XLEN{acc_q[0]}}};
    w_diff = acc_q[2*XLEN-1:XLEN-1] - {1'b0, mag_b_q};
    if (op_q inside {MU_DIV, MU_DIVU, MU_REM, MU_REMU}) begin
      w_step = w_diff[XLEN] ? {acc_q[2*XLEN-2:0], 1'b0}
                            : {w_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    end else begin
      w_step = {w_sum, acc_q[XLEN-1:1]};
    end
    w_prod = neg_q ? -w_step : w_step;
    w_qr   = (op_q inside {MU_REM, MU_REMU}) ? w_step[2*XLEN-1:XLEN] : w_step[XLEN-1:0];
    if (op_q inside {MU_DIV, MU_DIVU, MU_REM, MU_REMU}) begin
      w_final = neg_q ? -w_qr : w_qr;
    end else if (op_q == MU_MUL) begin
      w_final = w_prod[XLEN-1:0];
    end else begin
      w_final = w_prod[2*XLEN-1:XLEN];
    end
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    mag_b_d  = mag_b_q;
    neg_d    = neg_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    result_d = result_q;
    if (mdu_io.flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (mdu_io.in_valid) begin
            op_d    = mdu_io.op;
            mag_b_d = w_mag_b;
            neg_d   = w_neg;
            cnt_d   = '0;
            acc_d   = {{XLEN{1'b0}}, w_mag_a};
            if (w_special) begin
              result_d = w_special_res;
              state_d  = S_DONE;
`ifdef COTM32_MDU_FAST_MUL_EN
            end else if (w_is_mul) begin
              result_d = w_fast_res;
              state_d  = S_DONE;
`endif
            end else begin
              state_d = S_CALC;
            end
          end
        end
        S_CALC: begin
          acc_d = w_step;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            result_d = w_final;
            state_d  = S_DONE;
          end
        end
        S_DONE: begin
          if (mdu_io.out_ready) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      op_q     <= MU_NOP;
      mag_b_q  <= '0;
      neg_q    <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      mag_b_q  <= mag_b_d;
      neg_q    <= neg_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      result_q <= result_d;
    end
  end

  assign mdu_io.in_ready  = (state_q == S_IDLE) && !mdu_io.flush;
  assign mdu_io.out_valid = (state_q == S_DONE);
  assign mdu_io.busy      = (state_q != S_IDLE);
  assign mdu_io.result    = result_q;
endmodule
`default_nettype wire

// File: tb/tb_cotm32_mdu.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_cotm32_mdu: randomized and directed bench for cotm32_mdu against an
// arithmetic reference model.  Rev 1.0
// ----------------------------------------------------------------------------
module tb_cotm32_mdu;
  import cotm32_mdu_pkg::*;

  localparam int XLEN = 32;

  typedef struct {
    mu_op_t      op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  cotm32_mdu_if #(.XLEN(XLEN)) mdu_io ();

  cotm32_mdu #(.XLEN(XLEN)) u_dut (
    .clk    (clk),
    .rst    (rst),
    .mdu_io (mdu_io)
  );

  function automatic logic [31:0] ref_model(mu_op_t op, logic [31:0] a, logic [31:0] b);
    logic signed [63:0] sa, sb;
    logic        [63:0] ua, ub, p;
    logic        [31:0] r;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'h0, a};
    ub = {32'h0, b};
    r  = '0;
    case (op)
      MU_MUL:    begin p = sa * sb;          r = p[31:0];  end
      MU_MULH:   begin p = sa * sb;          r = p[63:32]; end
      MU_MULHSU: begin p = sa * $signed(ub); r = p[63:32]; end
      MU_MULHU:  begin p = ua * ub;          r = p[63:32]; end
      MU_DIV: begin
        if (b == 0) r = '1;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = a;
        else begin p = sa / sb; r = p[31:0]; end
      end
      MU_REM: begin
        if (b == 0) r = a;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = '0;
        else begin p = sa % sb; r = p[31:0]; end
      end
      MU_DIVU: begin
        if (b == 0) r = '1;
        else begin p = ua / ub; r = p[31:0]; end
      end
      MU_REMU: begin
        if (b == 0) r = a;
        else begin p = ua % ub; r = p[31:0]; end
      end
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic int exp_lat(mu_op_t op, logic [31:0] a, logic [31:0] b);
    int lat;
    lat = 1;
    if (op inside {MU_MUL, MU_MULH, MU_MULHSU, MU_MULHU}) begin
`ifdef COTM32_MDU_FAST_MUL_EN
      lat = 1;
`else
      lat = XLEN + 1;
`endif
    end else if (op inside {MU_DIV, MU_DIVU, MU_REM, MU_REMU}) begin
      if (b == 0) lat = 1;
      else if ((op inside {MU_DIV, MU_REM}) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) lat = 1;
      else lat = XLEN + 1;
    end
    return lat;
  endfunction

  // Offer a request at the negedge; returns with the accept edge just passed.
  task automatic issue(input mu_op_t op, input logic [31:0] a, input logic [31:0] b,
                       output logic rdy);
    @(negedge clk);
    mdu_io.in_valid = 1'b1;
    mdu_io.op       = op;
    mdu_io.a        = a;
    mdu_io.b        = b;
    rdy             = mdu_io.in_ready;
    @(posedge clk);
    #1;
    mdu_io.in_valid = 1'b0;
  endtask

  // Cycle index (accept edge = 0) at which out_valid is first seen; 0 on timeout.
  task automatic wait_valid(output int lat);
    lat = 0;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (mdu_io.out_valid) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic consume();
    mdu_io.out_ready = 1'b1;
    @(posedge clk);
    #1;
    mdu_io.out_ready = 1'b0;
  endtask

  task automatic recover();
    @(negedge clk);
    mdu_io.flush = 1'b1;
    @(posedge clk);
    #1;
    mdu_io.flush = 1'b0;
  endtask

  task automatic run(input mu_op_t op, input logic [31:0] a, input logic [31:0] b,
                     output logic [31:0] res, output int lat);
    logic rdy;
    issue(op, a, b, rdy);
    wait_valid(lat);
    res = mdu_io.result;
    if (lat == 0) recover();
    else consume();
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (mdu_io.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b expected 1", mdu_io.in_ready); end
    checks++;
    if (mdu_io.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b expected 0", mdu_io.out_valid); end
    checks++;
    if (mdu_io.busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", mdu_io.busy); end
    checks++;
    if (mdu_io.result !== 32'h0) begin failures++; $display("FAIL reset_result: got %h expected 0", mdu_io.result); end
    rst = 1'b0;
  endtask

  task automatic test_directed();
    vec_t        tbl [15];
    logic [31:0] res;
    int          lat;
    tbl = '{
      '{MU_MUL,    32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB},
      '{MU_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000},
      '{MU_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE},
      '{MU_MULHSU, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF},
      '{MU_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD},
      '{MU_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF},
      '{MU_DIVU,   32'd100,       32'd7,         32'd14},
      '{MU_REMU,   32'd100,       32'd7,         32'd2},
      '{MU_DIV,    32'd5,         32'd0,         32'hFFFF_FFFF},
      '{MU_REM,    32'd5,         32'd0,         32'd5},
      '{MU_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000},
      '{MU_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0},
      '{MU_NOP,    32'd123,       32'd456,       32'd0},
      '{MU_DIVU,   32'd5,         32'd0,         32'hFFFF_FFFF},
      '{MU_REMU,   32'd9,         32'd0,         32'd9}
    };
    foreach (tbl[i]) begin
      run(tbl[i].op, tbl[i].a, tbl[i].b, res, lat);
      checks++;
      if (res !== tbl[i].r) begin
        failures++;
        $display("FAIL dir_result[%0d] op=%s: got %h expected %h", i, tbl[i].op.name(), res, tbl[i].r);
      end
      checks++;
      if (lat !== exp_lat(tbl[i].op, tbl[i].a, tbl[i].b)) begin
        failures++;
        $display("FAIL dir_latency[%0d] op=%s: got %0d expected %0d", i, tbl[i].op.name(), lat,
                 exp_lat(tbl[i].op, tbl[i].a, tbl[i].b));
      end
    end
  endtask

  task automatic test_random();
    mu_op_t      op;
    logic [31:0] a, b, res, exp;
    int          lat;
    for (int n = 0; n < 60; n++) begin
      op = mu_op_t'(4'($urandom_range(0, 8)));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: b = 32'hFFFF_FFFF;
        2: b = 32'($urandom_range(1, 15));
        3: a = 32'h8000_0000;
        4: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        default: ;
      endcase
      exp = ref_model(op, a, b);
      run(op, a, b, res, lat);
      checks++;
      if (res !== exp) begin
        failures++;
        $display("FAIL rnd_result op=%s a=%h b=%h: got %h expected %h", op.name(), a, b, res, exp);
      end
      checks++;
      if (lat !== exp_lat(op, a, b)) begin
        failures++;
        $display("FAIL rnd_latency op=%s a=%h b=%h: got %0d expected %0d", op.name(), a, b, lat, exp_lat(op, a, b));
      end
    end
  endtask

  task automatic test_backpressure();
    logic rdy;
    int   lat;
    issue(MU_DIVU, 32'd1000, 32'd3, rdy);
    wait_valid(lat);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (mdu_io.out_valid !== 1'b1 || mdu_io.result !== 32'd333) begin
        failures++;
        $display("FAIL bp_hold[%0d]: got valid=%b result=%h expected valid=1 result=%h", k,
                 mdu_io.out_valid, mdu_io.result, 32'd333);
      end
      checks++;
      if (mdu_io.in_ready !== 1'b0) begin
        failures++;
        $display("FAIL bp_in_ready[%0d]: got %b expected 0", k, mdu_io.in_ready);
      end
    end
    consume();
    @(negedge clk);
    checks++;
    if (mdu_io.in_ready !== 1'b1 || mdu_io.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_release: got in_ready=%b out_valid=%b expected in_ready=1 out_valid=0",
               mdu_io.in_ready, mdu_io.out_valid);
    end
  endtask

  task automatic test_flush();
    logic        rdy, seen;
    logic [31:0] a, b, res;
    int          lat;
    seen = 1'b0;
    issue(MU_DIV, 32'h7654_3210, 32'd9, rdy);
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      seen = seen | mdu_io.out_valid;
    end
    @(negedge clk);
    mdu_io.flush    = 1'b1;
    mdu_io.in_valid = 1'b1;
    mdu_io.op       = MU_MUL;
    #1;
    checks++;
    if (mdu_io.in_ready !== 1'b0) begin failures++; $display("FAIL flush_in_ready: got %b expected 0", mdu_io.in_ready); end
    @(posedge clk);
    #1;
    mdu_io.flush    = 1'b0;
    mdu_io.in_valid = 1'b0;
    for (int k = 11; k <= 50; k++) begin
      @(negedge clk);
      if (k == 11) begin
        checks++;
        if (mdu_io.in_ready !== 1'b1 || mdu_io.busy !== 1'b0) begin
          failures++;
          $display("FAIL flush_idle: got in_ready=%b busy=%b expected in_ready=1 busy=0", mdu_io.in_ready, mdu_io.busy);
        end
      end
      seen = seen | mdu_io.out_valid;
    end
    checks++;
    if (seen !== 1'b0) begin failures++; $display("FAIL flush_no_valid: got %b expected 0", seen); end
    a = $urandom;
    b = $urandom;
    run(MU_MUL, a, b, res, lat);
    checks++;
    if (res !== ref_model(MU_MUL, a, b)) begin
      failures++;
      $display("FAIL flush_next_mul: got %h expected %h", res, ref_model(MU_MUL, a, b));
    end
    // A request offered together with flush in IDLE must be dropped.
    @(negedge clk);
    mdu_io.flush    = 1'b1;
    mdu_io.in_valid = 1'b1;
    mdu_io.op       = MU_DIVU;
    @(posedge clk);
    #1;
    mdu_io.flush    = 1'b0;
    mdu_io.in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (mdu_io.busy !== 1'b0) begin failures++; $display("FAIL flush_idle_drop: got busy=%b expected 0", mdu_io.busy); end
  endtask

  task automatic test_reset_mid();
    logic        rdy;
    logic [31:0] a, b, res;
    int          lat;
    a = 32'h9ABC_DEF1;
    b = 32'h1234_5679;
    issue(MU_MULH, a, b, rdy);
    repeat (4) @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    checks++;
    if (mdu_io.out_valid !== 1'b0 || mdu_io.busy !== 1'b0 || mdu_io.in_ready !== 1'b1 || mdu_io.result !== 32'h0) begin
      failures++;
      $display("FAIL rst_mid: got valid=%b busy=%b in_ready=%b result=%h expected 0 0 1 00000000",
               mdu_io.out_valid, mdu_io.busy, mdu_io.in_ready, mdu_io.result);
    end
    rst = 1'b0;
    run(MU_MULH, a, b, res, lat);
    checks++;
    if (res !== ref_model(MU_MULH, a, b)) begin
      failures++;
      $display("FAIL rst_next_mulh: got %h expected %h", res, ref_model(MU_MULH, a, b));
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] r1, r2;
    int          l1, l2;
    run(MU_REM, 32'hFFFF_FF00, 32'd7, r1, l1);
    run(MU_MULHU, 32'hDEAD_BEEF, 32'hCAFE_F00D, r2, l2);
    checks++;
    if (r1 !== ref_model(MU_REM, 32'hFFFF_FF00, 32'd7)) begin
      failures++;
      $display("FAIL b2b_first: got %h expected %h", r1, ref_model(MU_REM, 32'hFFFF_FF00, 32'd7));
    end
    checks++;
    if (r2 !== ref_model(MU_MULHU, 32'hDEAD_BEEF, 32'hCAFE_F00D)) begin
      failures++;
      $display("FAIL b2b_second: got %h expected %h", r2, ref_model(MU_MULHU, 32'hDEAD_BEEF, 32'hCAFE_F00D));
    end
  endtask

  initial begin
    mdu_io.in_valid  = 1'b0;
    mdu_io.op        = MU_NOP;
    mdu_io.a         = '0;
    mdu_io.b         = '0;
    mdu_io.flush     = 1'b0;
    mdu_io.out_ready = 1'b0;
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
